sram_2rw_arbiter: RTL and testbench

- Shares one dual-port (2rw) SRAM wrapper between NUM_REQ requesters using round-robin arbitration.
- Grants up to two requests per cycle, one per SRAM port.
- Blocks same-address hazards between the two ports.
- Routes read data back to the issuing requester one cycle after grant.
- Sits between compute/DMA clients and the SRAM wrapper. Both wrapper port clocks are tied to this block's clock.

---
 rtl/sram_2rw_arbiter.sv | 120 ++++++++++++
 tb/tb_sram_2rw_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_2rw_arbiter.sv
// Round-robin arbiter sharing one dual-port SRAM among NUM_REQ requesters.
// Up to two grants per cycle; read data is routed back one cycle after grant.
module sram_2rw_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int IDX_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_dataIn,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0]  rsp_dataOut,
    output logic                           rw0_enable,
    output logic                           rw0_write,
    output logic [ADDR_WIDTH-1:0]          rw0_addr,
    output logic [DATA_WIDTH-1:0]          rw0_dataIn,
    input  logic [DATA_WIDTH-1:0]          rw0_dataOut,
    output logic                           rw1_enable,
    output logic                           rw1_write,
    output logic [ADDR_WIDTH-1:0]          rw1_addr,
    output logic [DATA_WIDTH-1:0]          rw1_dataIn,
    input  logic [DATA_WIDTH-1:0]          rw1_dataOut
);

    logic [IDX_WIDTH-1:0]  r_rr_ptr;
    logic                  r_tag_vld0, r_tag_vld1;
    logic [IDX_WIDTH-1:0]  r_tag_idx0, r_tag_idx1;

    logic [IDX_WIDTH-1:0]  w_scan;
    logic                  w_g0_vld, w_g1_vld;
    logic [IDX_WIDTH-1:0]  w_g0_idx, w_g1_idx;
    logic [ADDR_WIDTH-1:0] w_g0_addr;
    logic                  w_g0_wr;
    logic                  w_en0, w_en1;

    // Scan from the round-robin pointer; port 1 takes the next request that
    // does not hazard against port 0 (read/read to one address is allowed).
    always_comb begin
        w_scan    = '0;
        w_g0_vld  = 1'b0;
        w_g1_vld  = 1'b0;
        w_g0_idx  = '0;
        w_g1_idx  = '0;
        w_g0_addr = '0;
        w_g0_wr   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = IDX_WIDTH'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (req_valid[w_scan]) begin
                if (!w_g0_vld) begin
                    w_g0_vld  = 1'b1;
                    w_g0_idx  = w_scan;
                    w_g0_addr = req_addr[w_scan*ADDR_WIDTH +: ADDR_WIDTH];
                    w_g0_wr   = req_write[w_scan];
                end else if (!w_g1_vld &&
                             !((req_addr[w_scan*ADDR_WIDTH +: ADDR_WIDTH] == w_g0_addr) &&
                               (w_g0_wr || req_write[w_scan]))) begin
                    w_g1_vld = 1'b1;
                    w_g1_idx = w_scan;
                end
            end
        end
    end

    assign w_en0 = w_g0_vld & reset_n;
    assign w_en1 = w_g1_vld & reset_n;

    always_comb begin
        req_ready = '0;
        if (w_en0) req_ready[w_g0_idx] = 1'b1;
        if (w_en1) req_ready[w_g1_idx] = 1'b1;
    end

    assign rw0_enable = w_en0;
    assign rw0_write  = req_write[w_g0_idx];
    assign rw0_addr   = req_addr[w_g0_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign rw0_dataIn = req_dataIn[w_g0_idx*DATA_WIDTH +: DATA_WIDTH];
    assign rw1_enable = w_en1;
    assign rw1_write  = req_write[w_g1_idx];
    assign rw1_addr   = req_addr[w_g1_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign rw1_dataIn = req_dataIn[w_g1_idx*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_rr_ptr   <= '0;
            r_tag_vld0 <= 1'b0;
            r_tag_vld1 <= 1'b0;
            r_tag_idx0 <= '0;
            r_tag_idx1 <= '0;
        end else begin
            if (w_en1)
                r_rr_ptr <= IDX_WIDTH'((int'(w_g1_idx) + 1) % NUM_REQ);
            else if (w_en0)
                r_rr_ptr <= IDX_WIDTH'((int'(w_g0_idx) + 1) % NUM_REQ);
            r_tag_vld0 <= w_en0 && !rw0_write;
            r_tag_vld1 <= w_en1 && !rw1_write;
            r_tag_idx0 <= w_g0_idx;
            r_tag_idx1 <= w_g1_idx;
        end
    end

    // Responses are suppressed while reset is asserted so in-flight reads vanish.
    always_comb begin
        rsp_valid   = '0;
        rsp_dataOut = '0;
        if (reset_n && r_tag_vld0) begin
            rsp_valid[r_tag_idx0] = 1'b1;
            rsp_dataOut[r_tag_idx0*DATA_WIDTH +: DATA_WIDTH] = rw0_dataOut;
        end
        if (reset_n && r_tag_vld1) begin
            rsp_valid[r_tag_idx1] = 1'b1;
            rsp_dataOut[r_tag_idx1*DATA_WIDTH +: DATA_WIDTH] = rw1_dataOut;
        end
    end

endmodule

// File: tb/tb_sram_2rw_arbiter.sv
// Directed bench for sram_2rw_arbiter: grants checked inline, read responses
// checked by a scoreboard monitor against hand-computed data.
module tb_sram_2rw_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid, req_ready, req_write, rsp_valid;
    logic [39:0] req_addr;
    logic [127:0] req_dataIn, rsp_dataOut;
    logic        rw0_enable, rw0_write, rw1_enable, rw1_write;
    logic [9:0]  rw0_addr, rw1_addr;
    logic [31:0] rw0_dataIn, rw1_dataIn, rw0_dataOut, rw1_dataOut;

    always #5 clock = ~clock;

    sram_2rw_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_dataIn(req_dataIn),
        .rsp_valid(rsp_valid), .rsp_dataOut(rsp_dataOut),
        .rw0_enable(rw0_enable), .rw0_write(rw0_write), .rw0_addr(rw0_addr),
        .rw0_dataIn(rw0_dataIn), .rw0_dataOut(rw0_dataOut),
        .rw1_enable(rw1_enable), .rw1_write(rw1_write), .rw1_addr(rw1_addr),
        .rw1_dataIn(rw1_dataIn), .rw1_dataOut(rw1_dataOut)
    );

    // SRAM model: write at the edge, read data one cycle later.
    logic [31:0] mem [0:1023];
    bit loaded = 1'b0;
    always @(posedge clock) begin
        if (!loaded) begin
            loaded    <= 1'b1;
            mem[10'h005] <= 32'hDEADBEEF;
            mem[10'h010] <= 32'h10101010;
            mem[10'h020] <= 32'h20202020;
            mem[10'h050] <= 32'h50505050;
            mem[10'h200] <= 32'hC0DE0000;
            mem[10'h201] <= 32'hC0DE0001;
            mem[10'h202] <= 32'hC0DE0002;
            mem[10'h203] <= 32'hC0DE0003;
        end
        if (rw0_enable) begin
            if (rw0_write) mem[rw0_addr] <= rw0_dataIn;
            else           rw0_dataOut   <= mem[rw0_addr];
        end
        if (rw1_enable) begin
            if (rw1_write) mem[rw1_addr] <= rw1_dataIn;
            else           rw1_dataOut   <= mem[rw1_addr];
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    typedef struct { int due; int idx; logic [31:0] data; } exp_t;
    exp_t sbq[$];

    logic [3:0][9:0]  A;
    logic [3:0][31:0] D, E;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Monitor: every asserted rsp_valid must match a queued expectation due now.
    always @(negedge clock) begin
        int found;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid[i]) begin
                found = -1;
                for (int j = 0; j < sbq.size(); j++)
                    if (found < 0 && sbq[j].idx == i) found = j;
                total++;
                if (found < 0) begin
                    $display("FAIL rsp_unexpected req%0d: got %h with no read outstanding (cycle %0d)",
                             i, rsp_dataOut[i*32 +: 32], cyc);
                end else begin
                    if (sbq[found].due == cyc && rsp_dataOut[i*32 +: 32] === sbq[found].data)
                        passed++;
                    else
                        $display("FAIL rsp_req%0d: got %h at cycle %0d expected %h at cycle %0d",
                                 i, rsp_dataOut[i*32 +: 32], cyc, sbq[found].data, sbq[found].due);
                    sbq.delete(found);
                end
            end
        end
        for (int j = sbq.size() - 1; j >= 0; j--) begin
            if (sbq[j].due < cyc) begin
                total++;
                $display("FAIL rsp_missing req%0d: no response, expected %h at cycle %0d",
                         sbq[j].idx, sbq[j].data, sbq[j].due);
                sbq.delete(j);
            end
        end
    end

    task automatic step(input logic [3:0] v, input logic [3:0] w, input logic [3:0] exp_rdy,
                        input bit push, input string nm);
        req_valid  = v;
        req_write  = w;
        req_addr   = A;
        req_dataIn = D;
        @(negedge clock);
        chk(nm, 64'(req_ready), 64'(exp_rdy));
        if (push)
            for (int i = 0; i < 4; i++)
                if (exp_rdy[i] && !w[i]) sbq.push_back('{cyc + 1, i, E[i]});
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    task automatic set_all_reads();
        for (int i = 0; i < 4; i++) begin
            A[i] = 10'h200 + 10'(i);
            E[i] = 32'hC0DE0000 + 32'(i);
        end
        D = '0;
    endtask

    task automatic reset_checks(input string nm);
        @(negedge clock);
        chk({nm, "_ready"}, 64'(req_ready), 64'h0);
        chk({nm, "_enables"}, 64'({rw1_enable, rw0_enable}), 64'h0);
        chk({nm, "_rsp_valid"}, 64'(rsp_valid), 64'h0);
    endtask

    initial begin
        reset_n = 1'b0;
        set_all_reads();
        req_valid  = 4'b1111;
        req_write  = 4'b0000;
        req_addr   = A;
        req_dataIn = D;
        repeat (3) begin
            reset_checks("reset");
            adv();
        end
        reset_n = 1'b1;
        A = '0; D = '0; E = '0;
        step(4'b0000, 4'b0000, 4'b0000, 1'b1, "idle_ready");
        adv();

        // Dual grant from rr_ptr=0: req0 on port 0, req2 on port 1.
        A = '0; A[0] = 10'h010; A[2] = 10'h020;
        E = '0; E[0] = 32'h10101010; E[2] = 32'h20202020;
        step(4'b0101, 4'b0000, 4'b0101, 1'b1, "dual_ready");
        chk("dual_ports_en", 64'({rw1_enable, rw0_enable}), 64'h3);
        chk("dual_port0_addr", 64'(rw0_addr), 64'h010);
        chk("dual_port1_addr", 64'(rw1_addr), 64'h020);
        adv();

        // rr_ptr is now 3: all requesters valid -> grants {3,0}.
        set_all_reads();
        step(4'b1111, 4'b0000, 4'b1001, 1'b1, "ptr3_ready");
        adv();

        // Single read by req1 (rr_ptr 1 -> 2).
        A = '0; A[1] = 10'h005;
        E = '0; E[1] = 32'hDEADBEEF;
        step(4'b0010, 4'b0000, 4'b0010, 1'b1, "single_ready");
        adv();

        // Write/read hazard on 0x100: only the writer goes (rr_ptr 2 -> 1).
        A = '0; A[0] = 10'h100; A[1] = 10'h100;
        D = '0; D[0] = 32'hA5A5A5A5;
        E = '0;
        step(4'b0011, 4'b0001, 4'b0001, 1'b1, "conflict_ready");
        chk("conflict_port0_write", 64'({rw1_enable, rw0_write}), 64'h1);
        adv();
        E[1] = 32'hA5A5A5A5;
        step(4'b0010, 4'b0000, 4'b0010, 1'b1, "conflict_follow_ready");
        adv();

        // Read/read to the same address grants both (rr_ptr stays 2).
        E[0] = 32'hA5A5A5A5; E[1] = 32'hA5A5A5A5;
        step(4'b0011, 4'b0000, 4'b0011, 1'b1, "rdrd_ready");
        adv();

        // Move rr_ptr back to 0 via a lone req3 read.
        A = '0; A[3] = 10'h200;
        E = '0; E[3] = 32'hC0DE0000;
        step(4'b1000, 4'b0000, 4'b1000, 1'b1, "req3_ready");
        adv();

        // Write/write hazard: req1 skipped, req2 takes port 1.
        A = '0; A[0] = 10'h040; A[1] = 10'h040; A[2] = 10'h050;
        D = '0; D[0] = 32'h11111111; D[1] = 32'h22222222;
        E = '0; E[2] = 32'h50505050;
        step(4'b0111, 4'b0011, 4'b0101, 1'b1, "wwskip_ready");
        chk("wwskip_port0_addr", 64'(rw0_addr), 64'h040);
        chk("wwskip_port1_addr", 64'(rw1_addr), 64'h050);
        chk("wwskip_port_writes", 64'({rw1_write, rw0_write}), 64'h1);
        adv();
        step(4'b0010, 4'b0010, 4'b0010, 1'b1, "wwskip_follow_ready");
        adv();
        A = '0; A[3] = 10'h040;
        D = '0;
        E = '0; E[3] = 32'h22222222;
        step(4'b1000, 4'b0000, 4'b1000, 1'b1, "ww_readback_ready");
        adv();

        // Reset right after a read grant: its response must never appear.
        A = '0; A[2] = 10'h010;
        E = '0;
        step(4'b0100, 4'b0000, 4'b0100, 1'b0, "midreset_grant_ready");
        adv();
        reset_n = 1'b0;
        set_all_reads();
        req_valid = 4'b1111;
        req_addr  = A;
        repeat (2) begin
            reset_checks("midreset");
            adv();
        end
        reset_n = 1'b1;

        // Fairness from rr_ptr=0 with all four holding reads.
        step(4'b1111, 4'b0000, 4'b0011, 1'b1, "fair_c0_ready");
        adv();
        step(4'b1111, 4'b0000, 4'b1100, 1'b1, "fair_c1_ready");
        adv();
        step(4'b1111, 4'b0000, 4'b0011, 1'b1, "fair_c2_ready");
        adv();
        step(4'b1111, 4'b0000, 4'b1100, 1'b1, "fair_c3_ready");
        adv();

        A = '0;
        step(4'b0000, 4'b0000, 4'b0000, 1'b1, "final_idle_ready");
        repeat (3) adv();
        chk("scoreboard_drained", 64'(sbq.size()), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
